// File: rtl/prog_clockdiv.sv
// rtl/prog_clockdiv.sv - runtime-programmable glitch-free clock divider with edge pulses
//
// Divides iclk by 2*ohalf. A new half-period is staged in a shadow register
// and only becomes active at a period boundary (or on iclear), so oclk never
// shows a runt phase.
//
// Ports:
//   iclk      master clock, the only clock
//   irst_n    asynchronous active-low reset
//   ien       count enable; low freezes counter and oclk
//   iclear    synchronous restart (highest priority)
//   iload     one-cycle strobe capturing ihalf into the shadow register
//   ihalf     requested half-period in iclk cycles (0 treated as 1)
//   oclk      registered divided clock
//   orise     one-cycle pulse in the first cycle oclk reads 1
//   ofall     one-cycle pulse in the first cycle oclk reads 0
//   opending  shadow value captured but not yet applied
//   ohalf     active half-period
module prog_clockdiv #(
    parameter int          CNT_WIDTH    = 32,
    parameter int unsigned DEFAULT_HALF = 50000
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 ien,
    input  logic                 iclear,
    input  logic                 iload,
    input  logic [CNT_WIDTH-1:0] ihalf,
    output logic                 oclk,
    output logic                 orise,
    output logic                 ofall,
    output logic                 opending,
    output logic [CNT_WIDTH-1:0] ohalf
);

    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RESET_HALF =
        (CNT_WIDTH'(DEFAULT_HALF) == '0) ? ONE : CNT_WIDTH'(DEFAULT_HALF);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] shadow;
    logic [CNT_WIDTH-1:0] ihalf_cl;
    logic                 boundary;

    // A half-period of 0 would never terminate; treat it as 1.
    assign ihalf_cl = (ihalf == '0) ? ONE : ihalf;

    // ohalf is never 0, so ohalf-1 cannot wrap and count stays below ohalf.
    assign boundary = ien && !iclear && (count == ohalf - ONE);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            count    <= '0;
            oclk     <= 1'b0;
            orise    <= 1'b0;
            ofall    <= 1'b0;
            opending <= 1'b0;
            shadow   <= RESET_HALF;
            ohalf    <= RESET_HALF;
        end else if (iclear) begin
            count    <= '0;
            oclk     <= 1'b0;
            orise    <= 1'b0;
            ofall    <= oclk;
            opending <= 1'b0;
            if (iload) begin
                ohalf <= ihalf_cl;
            end else if (opending) begin
                ohalf <= shadow;
            end
        end else if (boundary) begin
            count <= '0;
            oclk  <= ~oclk;
            orise <= ~oclk;
            ofall <= oclk;
            // A load landing on the boundary applies directly and supersedes
            // any older pending value.
            if (iload) begin
                ohalf    <= ihalf_cl;
                shadow   <= ihalf_cl;
                opending <= 1'b0;
            end else if (opending) begin
                ohalf    <= shadow;
                opending <= 1'b0;
            end
        end else begin
            orise <= 1'b0;
            ofall <= 1'b0;
            if (ien) begin
                count <= count + ONE;
            end
            if (iload) begin
                shadow   <= ihalf_cl;
                opending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_clockdiv.sv
// tb/tb_prog_clockdiv.sv - self-checking bench for prog_clockdiv
module tb_prog_clockdiv;

    localparam int W = 8;

    logic         iclk = 1'b0;
    logic         irst_n = 1'b0;
    logic         ien = 1'b0;
    logic         iclear = 1'b0;
    logic         iload = 1'b0;
    logic [W-1:0] ihalf = '0;
    logic         oclk, orise, ofall, opending;
    logic [W-1:0] ohalf;

    int n_pass = 0;
    int n_total = 0;

    prog_clockdiv #(.CNT_WIDTH(W), .DEFAULT_HALF(4)) dut (
        .iclk(iclk), .irst_n(irst_n), .ien(ien), .iclear(iclear),
        .iload(iload), .ihalf(ihalf), .oclk(oclk), .orise(orise),
        .ofall(ofall), .opending(opending), .ohalf(ohalf)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic         en, clr, ld;
        logic [W-1:0] half;
        logic         oc, r, f, p;
        logic [W-1:0] h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, clr, ld, input int half,
                       input logic oc, r, f, p, input int h);
        vec_t v;
        v.en = en; v.clr = clr; v.ld = ld; v.half = W'(half);
        v.oc = oc; v.r = r; v.f = f; v.p = p; v.h = W'(h);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {clk,rise,fall,pend,half}=%b_%0d required %b_%0d",
                      name, got[W+3:W], got[W-1:0], exp[W+3:W], exp[W-1:0]);
    endtask

    function automatic logic [W+3:0] outs();
        return {oclk, orise, ofall, opending, ohalf};
    endfunction

    // Reference model: tracks the output level, the cycles remaining in the
    // current half-period, and the active / staged half-period values.
    logic m_lvl, m_r, m_f, m_p;
    int   m_h, m_sh, m_rem;

    function automatic int cl(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_r = 0; m_f = 0; m_p = 0;
        m_h = 4; m_sh = 4; m_rem = 4;
    endtask

    task automatic model_step(input logic en, clr, ld, input int half);
        m_r = 0; m_f = 0;
        if (clr) begin
            m_f = m_lvl;
            m_lvl = 0;
            if (ld) m_h = cl(half);
            else if (m_p) m_h = m_sh;
            m_p = 0;
            m_rem = m_h;
        end else if (en && m_rem == 1) begin
            m_r = !m_lvl;
            m_f = m_lvl;
            m_lvl = !m_lvl;
            if (ld) begin
                m_h = cl(half); m_sh = cl(half); m_p = 0;
            end else if (m_p) begin
                m_h = m_sh; m_p = 0;
            end
            m_rem = m_h;
        end else begin
            if (en) m_rem--;
            if (ld) begin
                m_sh = cl(half); m_p = 1;
            end
        end
    endtask

    initial begin
        // Default half 4: rise 4 cycles after release, load 2 mid-half.
        repeat (3) add(1,0,0,0, 0,0,0,0,4);
        add(1,0,0,0, 1,1,0,0,4);
        add(1,0,0,0, 1,0,0,0,4);
        add(1,0,1,2, 1,0,0,1,4);
        add(1,0,0,0, 1,0,0,1,4);
        add(1,0,0,0, 0,0,1,0,2);
        add(1,0,0,0, 0,0,0,0,2);
        add(1,0,0,0, 1,1,0,0,2);
        add(1,0,0,0, 1,0,0,0,2);
        add(1,0,0,0, 0,0,1,0,2);
        // Load 0 -> half of 1, iclk/2.
        add(1,0,1,0, 0,0,0,1,2);
        add(1,0,0,0, 1,1,0,0,1);
        add(1,0,0,0, 0,0,1,0,1);
        add(1,0,0,0, 1,1,0,0,1);
        add(1,0,0,0, 0,0,1,0,1);
        // Load on a boundary applies directly.
        add(1,0,1,4, 1,1,0,0,4);
        repeat (3) add(1,0,0,0, 1,0,0,0,4);
        add(1,0,0,0, 0,0,1,0,4);
        repeat (3) add(1,0,0,0, 0,0,0,0,4);
        add(1,0,0,0, 1,1,0,0,4);
        add(1,0,0,0, 1,0,0,0,4);
        // Enable dropped for 10 cycles mid-half.
        repeat (10) add(0,0,0,0, 1,0,0,0,4);
        repeat (2) add(1,0,0,0, 1,0,0,0,4);
        add(1,0,0,0, 0,0,1,0,4);
        repeat (3) add(1,0,0,0, 0,0,0,0,4);
        add(1,0,0,0, 1,1,0,0,4);
        // Clear while high with pending 6.
        add(1,0,1,6, 1,0,0,1,4);
        add(1,1,0,0, 0,0,1,0,6);
        repeat (5) add(1,0,0,0, 0,0,0,0,6);
        add(1,0,0,0, 1,1,0,0,6);

        repeat (2) @(posedge iclk);
        #1 irst_n = 1'b1;
        check("reset_state", outs(), {4'b0000, W'(4)});

        foreach (tbl[i]) begin
            ien = tbl[i].en; iclear = tbl[i].clr; iload = tbl[i].ld; ihalf = tbl[i].half;
            @(posedge iclk); #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].oc, tbl[i].r, tbl[i].f, tbl[i].p, tbl[i].h});
        end

        // Async reset mid-period with a load pending.
        ien = 1; iclear = 0; iload = 1; ihalf = W'(7);
        @(posedge iclk); #1;
        check("pend_before_rst", outs(), {4'b1001, W'(6)});
        iload = 0;
        #3 irst_n = 1'b0;
        #1 check("async_rst", outs(), {4'b0000, W'(4)});
        @(posedge iclk); #1;
        check("rst_held", outs(), {4'b0000, W'(4)});
        irst_n = 1'b1;
        model_reset();

        // Randomized run against the reference model.
        for (int n = 0; n < 2000; n++) begin
            ien    = ($urandom_range(0, 9) != 0);
            iclear = ($urandom_range(0, 39) == 0);
            iload  = ($urandom_range(0, 14) == 0);
            ihalf  = W'($urandom_range(0, 5));
            model_step(ien, iclear, iload, int'(ihalf));
            @(posedge iclk); #1;
            check($sformatf("rand%0d", n), outs(), {m_lvl, m_r, m_f, m_p, W'(m_h)});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
